branch_predict_ctrl: RTL and testbench

BRANCH_PREDICT_CTRL -- requirements
Module: branch_predict_ctrl

---
 rtl/branch_predict_ctrl.sv | 139 +++++++++++++
 tb/tb_branch_predict_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predict_ctrl.sv
// Branch prediction controller: direct-mapped BTB with per-entry prediction
// state, combinational fetch lookup, EX-stage resolve/update, mispredict
// detection and a saturating mispredict counter.
// Optional feature macro: BHT_2BIT_EN (2-bit saturating counters per entry).
// Without it, prediction is 1-bit: a valid hit predicts taken.

// One BTB entry: holds valid/tag/target (and counter) and applies its own
// update when the EX-stage resolve targets this index.
module bpc_entry #(
  parameter int TAG_W = 27
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             upd,
  input  logic             taken,
  input  logic [TAG_W-1:0] wtag,
  input  logic [31:0]      wtgt,
  output logic             valid,
  output logic [TAG_W-1:0] tag,
  output logic [31:0]      tgt,
  output logic             pt
);
  logic hit;
  assign hit = valid && (tag == wtag);

`ifdef BHT_2BIT_EN
  logic [1:0] ctr;

  // Allocate on taken miss (weak-T), train counter on hit; reset wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      ctr   <= 2'b01;
    end else if (upd) begin
      if (taken) begin
        valid <= 1'b1;
        tag   <= wtag;
        tgt   <= wtgt;
        ctr   <= !hit ? 2'b10 : ((ctr == 2'b11) ? 2'b11 : ctr + 2'd1);
      end else if (hit) begin
        ctr   <= (ctr == 2'b00) ? 2'b00 : ctr - 2'd1;
      end
    end
  end

  assign pt = ctr[1];
`else
  // Taken resolve allocates/refreshes; not-taken hit drops the entry.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
    end else if (upd) begin
      if (taken) begin
        valid <= 1'b1;
        tag   <= wtag;
        tgt   <= wtgt;
      end else if (hit) begin
        valid <= 1'b0;
      end
    end
  end

  assign pt = valid;
`endif
endmodule

module branch_predict_ctrl #(
  parameter int IDX_BITS = 3
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST,
  input  logic [31:0] PCF,
  output logic        PredTakenF,
  output logic [31:0] PredTargetF,
  input  logic        ValidE,
  input  logic [31:0] PCE,
  input  logic [2:0]  BranchTypeE,
  input  logic        BranchE,
  input  logic [31:0] BranchTargetE,
  input  logic        PredTakenE,
  input  logic [31:0] PredTargetE,
  output logic        MispredictE,
  output logic [31:0] RedirectPCE,
  output logic [15:0] MispredCnt
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 32 - IDX_BITS - 2;

  logic [ENTRIES-1:0]            e_valid;
  logic [ENTRIES-1:0][TAG_W-1:0] e_tag;
  logic [ENTRIES-1:0][31:0]      e_tgt;
  logic [ENTRIES-1:0]            e_pt;

  logic [IDX_BITS-1:0] idx_f, idx_e;
  logic [TAG_W-1:0]    tag_f, tag_e;
  logic                resolve, hit_f;

  assign idx_f   = PCF[IDX_BITS+1:2];
  assign tag_f   = PCF[31:IDX_BITS+2];
  assign idx_e   = PCE[IDX_BITS+1:2];
  assign tag_e   = PCE[31:IDX_BITS+2];
  assign resolve = ValidE && (BranchTypeE != 3'b000);

  // Word-aligned fetch PC: the byte-offset bits never reach the table.
  logic unused_pcf_lsb;
  assign unused_pcf_lsb = ^PCF[1:0];

  for (genvar i = 0; i < ENTRIES; i++) begin : g_ent
    bpc_entry #(.TAG_W(TAG_W)) u_ent (
      .clk   (CPU_CLK),
      .rst   (CPU_RST),
      .upd   (resolve && (idx_e == IDX_BITS'(i))),
      .taken (BranchE),
      .wtag  (tag_e),
      .wtgt  (BranchTargetE),
      .valid (e_valid[i]),
      .tag   (e_tag[i]),
      .tgt   (e_tgt[i]),
      .pt    (e_pt[i])
    );
  end

  // Fetch lookup reads current (pre-update) contents; no write bypass.
  assign hit_f       = e_valid[idx_f] && (e_tag[idx_f] == tag_f);
  assign PredTakenF  = hit_f && e_pt[idx_f];
  assign PredTargetF = hit_f ? e_tgt[idx_f] : 32'h0;

  assign MispredictE = resolve && ((PredTakenE != BranchE) ||
                                   (BranchE && (PredTargetE != BranchTargetE)));
  assign RedirectPCE = BranchE ? BranchTargetE : PCE + 32'd4;

  // Saturating mispredict counter; reset clears it.
  always_ff @(posedge CPU_CLK) begin
    if (CPU_RST)
      MispredCnt <= 16'h0;
    else if (MispredictE && (MispredCnt != 16'hFFFF))
      MispredCnt <= MispredCnt + 16'd1;
  end
endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Bench for branch_predict_ctrl: directed vectors, an array-based model of
// the predictor checked every cycle at negedge, plus literal expectations.
module tb_branch_predict_ctrl;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pcf = '0;
  logic        predtakenf;
  logic [31:0] predtargetf;
  logic        vld = 1'b0;
  logic [31:0] pce = '0;
  logic [2:0]  bt = '0;
  logic        br = 1'b0;
  logic [31:0] btgt = '0;
  logic        pt = 1'b0;
  logic [31:0] ptgt = '0;
  logic        mis;
  logic [31:0] redir;
  logic [15:0] cnt;

  int tests = 0;
  int fails = 0;

  // model state: per index, valid / full-PC tag / target / counter
  bit          m_v   [8];
  int unsigned m_tag [8];
  int unsigned m_tgt [8];
  int          m_ctr [8];
  int          m_cnt = 0;
  bit          chk_en = 1'b0;

  branch_predict_ctrl dut (
    .CPU_CLK(clk), .CPU_RST(rst), .PCF(pcf),
    .PredTakenF(predtakenf), .PredTargetF(predtargetf),
    .ValidE(vld), .PCE(pce), .BranchTypeE(bt), .BranchE(br),
    .BranchTargetE(btgt), .PredTakenE(pt), .PredTargetE(ptgt),
    .MispredictE(mis), .RedirectPCE(redir), .MispredCnt(cnt)
  );

  always #5 clk = ~clk;

  function automatic int unsigned ix(input logic [31:0] pc);
    return (pc >> 2) % 8;
  endfunction

  function automatic bit exp_mis();
    return vld && (bt != 0) && ((pt != br) || (br && ptgt != btgt));
  endfunction

  // model update at each active edge
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin m_v[i] = 0; m_ctr[i] = 1; end
      m_cnt  = 0;
      chk_en = 1'b1;
    end else begin
      if (exp_mis() && m_cnt < 65535) m_cnt = m_cnt + 1;
      if (vld && bt != 0) begin
        int unsigned i;
        bit h;
        i = ix(pce);
        h = m_v[i] && (m_tag[i] == (pce >> 5));
        if (br) begin
          m_ctr[i] = h ? ((m_ctr[i] + 1 > 3) ? 3 : m_ctr[i] + 1) : 2;
          m_v[i] = 1; m_tag[i] = pce >> 5; m_tgt[i] = btgt;
        end else if (h) begin
`ifdef BHT_2BIT_EN
          m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
`else
          m_v[i] = 0;
`endif
        end
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    if (chk_en) begin
      int unsigned i;
      bit h, ept;
      logic [31:0] etg;
      i   = ix(pcf);
      h   = m_v[i] && (m_tag[i] == (pcf >> 5));
`ifdef BHT_2BIT_EN
      ept = h && (m_ctr[i] >= 2);
`else
      ept = h;
`endif
      etg = h ? m_tgt[i] : 32'h0;
      tests++;
      if (predtakenf !== ept || predtargetf !== etg || mis !== exp_mis() ||
          cnt !== 16'(m_cnt) || (exp_mis() && redir !== (br ? btgt : pce + 32'd4))) begin
        fails++;
        $display("FAIL model t=%0t pcf=%h: pt=%b/%b tgt=%h/%h mis=%b/%b cnt=%h/%h redir=%h (act/exp)",
                 $time, pcf, predtakenf, ept, predtargetf, etg, mis, exp_mis(),
                 cnt, 16'(m_cnt), redir);
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drv(input logic [31:0] f, input logic v, input logic [31:0] e,
                     input logic [2:0] t, input logic b, input logic [31:0] bg,
                     input logic p, input logic [31:0] pg);
    pcf = f; vld = v; pce = e; bt = t; br = b; btgt = bg; pt = p; ptgt = pg;
    #1;
  endtask

  task automatic idle(input logic [31:0] f);
    drv(f, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    tick(); tick();
    rst = 1'b0;
    // reset state
    idle(32'h100);
    chk("rst_pt", 32'(predtakenf), 0);
    chk("rst_tgt", predtargetf, 0);
    chk("rst_cnt", 32'(cnt), 0);
    tick();
    // first taken resolve allocates
    drv(32'h0, 1, 32'h100, 3'd1, 1, 32'h200, 0, 0);
    chk("alloc_mis", 32'(mis), 1);
    chk("alloc_redir", redir, 32'h200);
    tick();
    idle(32'h100);
    chk("alloc_pt", 32'(predtakenf), 1);
    chk("alloc_tgt", predtargetf, 32'h200);
    chk("alloc_cnt", 32'(cnt), 1);
    tick();
    // not taken, predicted taken
    drv(32'h0, 1, 32'h100, 3'd2, 0, 32'h200, 1, 32'h200);
    chk("nt_mis", 32'(mis), 1);
    chk("nt_redir", redir, 32'h104);
    tick();
    idle(32'h100);
    chk("nt_pt", 32'(predtakenf), 0);
`ifdef BHT_2BIT_EN
    chk("nt_tgt", predtargetf, 32'h200);
`else
    chk("nt_tgt", predtargetf, 32'h0);
`endif
    tick();
    drv(32'h0, 1, 32'h100, 3'd1, 1, 32'h200, 0, 0);
    tick();
    idle(32'h100);
    chk("retrain_pt", 32'(predtakenf), 1);
    chk("retrain_cnt", 32'(cnt), 3);
    tick();
    // alias replaces entry
    drv(32'h0, 1, 32'h120, 3'd1, 1, 32'h300, 0, 0);
    tick();
    idle(32'h100);
    chk("alias_old_pt", 32'(predtakenf), 0);
    chk("alias_old_tgt", predtargetf, 0);
    tick();
    idle(32'h120);
    chk("alias_new_pt", 32'(predtakenf), 1);
    chk("alias_new_tgt", predtargetf, 32'h300);
    tick();
    // same-cycle read/write: no bypass
    drv(32'h108, 1, 32'h108, 3'd1, 1, 32'h400, 0, 0);
    chk("same_pt", 32'(predtakenf), 0);
    tick();
    idle(32'h108);
    chk("same_next_pt", 32'(predtakenf), 1);
    tick();
    // gated resolves: no update, no mispredict
    drv(32'h10C, 0, 32'h10C, 3'd1, 1, 32'h500, 0, 0);
    chk("novld_mis", 32'(mis), 0);
    tick();
    drv(32'h10C, 1, 32'h10C, 3'd0, 1, 32'h500, 0, 0);
    chk("nobr_mis", 32'(mis), 0);
    tick();
    idle(32'h10C);
    chk("gated_pt", 32'(predtakenf), 0);
    tick();
    // target mismatch with correct direction
    drv(32'h108, 1, 32'h108, 3'd1, 1, 32'h444, 1, 32'h400);
    chk("tgtmis_mis", 32'(mis), 1);
    chk("tgtmis_redir", redir, 32'h444);
    tick();
    drv(32'h108, 1, 32'h108, 3'd1, 1, 32'h444, 1, 32'h444);
    chk("correct_mis", 32'(mis), 0);
    tick();
    drv(32'h108, 1, 32'h108, 3'd1, 1, 32'h444, 1, 32'h444);
    tick();
    // train down; model tracks counter / invalidation
    for (int k = 0; k < 4; k++) begin
      drv(32'h108, 1, 32'h108, 3'd3, 0, 32'h0, 1, 32'h444);
      tick();
    end
    idle(32'h108);
    chk("down_pt", 32'(predtakenf), 0);
    // redirect wrap
    drv(32'h0, 1, 32'hFFFF_FFFC, 3'd1, 0, 32'h0, 1, 32'h10);
    chk("wrap_redir", redir, 32'h0);
    tick();
    // reset mid-operation drops the pending allocation
    rst = 1'b1;
    drv(32'h110, 1, 32'h110, 3'd1, 1, 32'h600, 0, 0);
    tick();
    rst = 1'b0;
    idle(32'h110);
    chk("midrst_pt", 32'(predtakenf), 0);
    chk("midrst_cnt", 32'(cnt), 0);
    tick();
    // saturate the counter
    drv(32'h180, 1, 32'h180, 3'd1, 1, 32'h700, 0, 0);
    for (int k = 0; k < 70000; k++) tick();
    chk("sat_cnt", 32'(cnt), 32'hFFFF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle(32'h100);
    chk("sat_rst_cnt", 32'(cnt), 0);
    chk("sat_rst_pt", 32'(predtakenf), 0);
    tick();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
